// File: rtl/readback_usb_cdc_tx_pkg.sv
// Shared definitions for the readback return path: FSM encoding, packet
// framing constants and the byte-lane selector used while serializing words.
package readback_usb_cdc_tx_pkg;

    typedef enum logic [2:0] {
        ST_FILL     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_LENGTH   = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_CHECKSUM = 3'd4
    } state_e;

    localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

    // Header + length + checksum; host-side tests use it to size packets.
    localparam int PKT_OVERHEAD_BYTES = 3;

    // Byte idx is the transmit order within a word (0 goes out first).
    function automatic logic [7:0] word_byte(input logic [31:0] w,
                                             input logic [1:0]  idx,
                                             input logic        big_endian);
        logic [1:0] sel;
        sel = big_endian ? ~idx : idx;
        case (sel)
            2'd0:    word_byte = w[7:0];
            2'd1:    word_byte = w[15:8];
            2'd2:    word_byte = w[23:16];
            default: word_byte = w[31:24];
        endcase
    endfunction

endpackage

// File: rtl/readback_usb_cdc_tx_word_buffer.sv
// Packet word store: append-only write at the fill count, combinational read
// at an arbitrary index. Reset and clear drop the count; storage is left as is.
module readback_word_buffer #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             we_i,
    input  logic             clr_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [IDX_W-1:0] count_o,
    output logic [31:0]      rdata_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      mem_q [DEPTH];
    logic [IDX_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (we_i) begin
            count_d = count_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Writes only happen while count < DEPTH, so the low bits address the array.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[count_q[AW-1:0]] <= wdata_i;
        end
    end

    assign count_o = count_q;
    assign rdata_o = mem_q[rd_idx_i[AW-1:0]];

endmodule

// File: rtl/readback_usb_cdc_tx.sv
// Collects 32-bit readback words into a packet and streams it to the usb_cdc
// IN channel as HEADER, LENGTH, 4N payload bytes and an XOR checksum.
module readback_usb_cdc_tx
    import readback_usb_cdc_tx_pkg::*;
#(
    parameter int         BUFFER_WORDS = 16,
    parameter logic [7:0] HEADER_BYTE  = DEFAULT_HEADER_BYTE,
    parameter bit         BIG_ENDIAN   = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [31:0] word_data_i,
    input  logic        word_valid_i,
    input  logic        word_last_i,
    output logic        word_ready_o,
    input  logic        flush_i,
    output logic [7:0]  in_data_o,
    output logic        in_valid_o,
    input  logic        in_ready_i,
    output logic        busy_o,
    output logic [15:0] packets_sent_o
);

    localparam int               IDX_W    = $clog2(BUFFER_WORDS + 1);
    localparam logic [IDX_W-1:0] FULL_CNT = IDX_W'(BUFFER_WORDS);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       in_data_q, in_data_d;
    logic             in_valid_q, in_valid_d;
    logic             word_ready_q, word_ready_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;

    logic             accept, hs, close, last_byte;
    logic             buf_we, buf_clr;
    logic [IDX_W-1:0] buf_count, cnt_after, nxt_widx;
    logic [1:0]       nxt_bidx;
    logic [31:0]      rdata;
    logic [7:0]       nxt_byte;

    readback_word_buffer #(
        .DEPTH (BUFFER_WORDS),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .we_i      (buf_we),
        .clr_i     (buf_clr),
        .wdata_i   (word_data_i),
        .rd_idx_i  (nxt_widx),
        .count_o   (buf_count),
        .rdata_o   (rdata)
    );

    assign accept    = word_valid_i && word_ready_q && (state_q == ST_FILL);
    assign hs        = in_valid_q && in_ready_i;
    assign cnt_after = buf_count + IDX_W'(accept);
    assign close     = (accept && (word_last_i || cnt_after == FULL_CNT)) ||
                       (flush_i && cnt_after != '0);
    assign last_byte = (byte_idx_q == 2'd3) && (word_idx_q == buf_count - IDX_W'(1));
    assign buf_we    = accept;
    assign buf_clr   = (state_q == ST_CHECKSUM) && hs;

    // Lookahead position: the byte to register on the next handshake.
    always_comb begin
        nxt_bidx = 2'd0;
        nxt_widx = '0;
        if (state_q == ST_PAYLOAD) begin
            nxt_bidx = byte_idx_q + 2'd1;
            nxt_widx = (byte_idx_q == 2'd3) ? word_idx_q + IDX_W'(1) : word_idx_q;
        end
    end

    assign nxt_byte = word_byte(rdata, nxt_bidx, BIG_ENDIAN);

    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        csum_d       = csum_q;
        in_data_d    = in_data_q;
        in_valid_d   = in_valid_q;
        word_ready_d = word_ready_q;
        pkt_cnt_d    = pkt_cnt_q;
        case (state_q)
            ST_FILL: begin
                if (close) begin
                    state_d      = ST_HEADER;
                    in_valid_d   = 1'b1;
                    in_data_d    = HEADER_BYTE;
                    word_ready_d = 1'b0;
                end else begin
                    word_ready_d = 1'b1;
                end
            end
            ST_HEADER: begin
                if (hs) begin
                    state_d   = ST_LENGTH;
                    in_data_d = 8'(buf_count);
                    csum_d    = 8'(buf_count);
                end
            end
            ST_LENGTH: begin
                if (hs) begin
                    state_d    = ST_PAYLOAD;
                    word_idx_d = nxt_widx;
                    byte_idx_d = nxt_bidx;
                    in_data_d  = nxt_byte;
                    csum_d     = csum_q ^ nxt_byte;
                end
            end
            ST_PAYLOAD: begin
                if (hs) begin
                    if (last_byte) begin
                        state_d   = ST_CHECKSUM;
                        in_data_d = csum_q;
                    end else begin
                        word_idx_d = nxt_widx;
                        byte_idx_d = nxt_bidx;
                        in_data_d  = nxt_byte;
                        csum_d     = csum_q ^ nxt_byte;
                    end
                end
            end
            ST_CHECKSUM: begin
                if (hs) begin
                    state_d      = ST_FILL;
                    in_valid_d   = 1'b0;
                    in_data_d    = 8'h00;
                    word_ready_d = 1'b1;
                    pkt_cnt_d    = pkt_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d      = ST_FILL;
                in_valid_d   = 1'b0;
                word_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_FILL;
            word_idx_q   <= '0;
            byte_idx_q   <= 2'd0;
            csum_q       <= 8'h00;
            in_data_q    <= 8'h00;
            in_valid_q   <= 1'b0;
            word_ready_q <= 1'b0;
            pkt_cnt_q    <= 16'h0000;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            csum_q       <= csum_d;
            in_data_q    <= in_data_d;
            in_valid_q   <= in_valid_d;
            word_ready_q <= word_ready_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign word_ready_o   = word_ready_q;
    assign in_data_o      = in_data_q;
    assign in_valid_o     = in_valid_q;
    assign busy_o         = (state_q != ST_FILL);
    assign packets_sent_o = pkt_cnt_q;

endmodule

// File: tb/tb_readback_usb_cdc_tx.sv
// Scoreboard bench: two instances (big/little endian) share stimulus; a packet
// model queues expected bytes, per-instance monitors pop and compare.
module tb_readback_usb_cdc_tx;

    localparam int         BW  = 4;
    localparam logic [7:0] HDR = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] word_data = '0;
    logic        word_valid = 1'b0, word_last = 1'b0, flush = 1'b0, in_ready = 1'b0;
    logic        word_ready [2];
    logic [7:0]  in_data [2];
    logic        in_valid [2];
    logic        busy [2];
    logic [15:0] pkts [2];

    always #5 clk = ~clk;

    readback_usb_cdc_tx #(.BUFFER_WORDS(BW), .HEADER_BYTE(HDR), .BIG_ENDIAN(1'b1)) u_dut_be (
        .clk_i(clk), .reset_n_i(rst_n), .word_data_i(word_data), .word_valid_i(word_valid),
        .word_last_i(word_last), .word_ready_o(word_ready[0]), .flush_i(flush),
        .in_data_o(in_data[0]), .in_valid_o(in_valid[0]), .in_ready_i(in_ready),
        .busy_o(busy[0]), .packets_sent_o(pkts[0]));

    readback_usb_cdc_tx #(.BUFFER_WORDS(BW), .HEADER_BYTE(HDR), .BIG_ENDIAN(1'b0)) u_dut_le (
        .clk_i(clk), .reset_n_i(rst_n), .word_data_i(word_data), .word_valid_i(word_valid),
        .word_last_i(word_last), .word_ready_o(word_ready[1]), .flush_i(flush),
        .in_data_o(in_data[1]), .in_valid_o(in_valid[1]), .in_ready_i(in_ready),
        .busy_o(busy[1]), .packets_sent_o(pkts[1]));

    int          n_checks = 0, n_fail = 0;
    logic [8:0]  exp_q [2][$];   // {last_of_packet, byte}
    logic [31:0] model_buf [$];
    int          model_pkts [2];
    int          bytes_seen [2];
    bit          rdy_rand = 1'b0, stall_arm = 1'b0;
    int          stall_at = 0, stall_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // k-th transmitted byte of word w
    function automatic logic [7:0] pick(input logic [31:0] w, input int k, input bit be);
        int sh;
        sh = be ? 8 * (3 - k) : 8 * k;
        return 8'(w >> sh);
    endfunction

    task automatic close_pkt();
        for (int g = 0; g < 2; g++) begin
            logic [7:0] cs, b;
            cs = 8'(model_buf.size());
            exp_q[g].push_back({1'b0, HDR});
            exp_q[g].push_back({1'b0, cs});
            foreach (model_buf[i]) begin
                for (int k = 0; k < 4; k++) begin
                    b  = pick(model_buf[i], k, g == 0);
                    cs = cs ^ b;
                    exp_q[g].push_back({1'b0, b});
                end
            end
            exp_q[g].push_back({1'b1, cs});
        end
        model_buf.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the word is taken.
    task automatic send_word(input logic [31:0] d, input bit last, input bit fl);
        int t;
        word_data = d; word_valid = 1'b1; word_last = last; flush = fl;
        t = 0;
        forever begin
            @(negedge clk);
            if (word_ready[0]) begin
                model_buf.push_back(d);
                if (last || fl || model_buf.size() == BW) close_pkt();
                break;
            end
            t++;
            if (t > 3000) begin
                n_checks++; n_fail++;
                $display("FAIL send_word_timeout: word %08h never accepted", d);
                break;
            end
        end
        @(posedge clk); #1;
        word_valid = 1'b0; word_last = 1'b0; flush = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        if (!busy[0] && model_buf.size() > 0) close_pkt();
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((exp_q[0].size() > 0 || exp_q[1].size() > 0 || busy[0] || busy[1]) && t < 3000);
        if (t >= 3000) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: %0d/%0d bytes still expected", exp_q[0].size(), exp_q[1].size());
        end
        chk("queue_drained", exp_q[0].size() + exp_q[1].size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s_word_ready[%0d]", tag, g), word_ready[g], 1'b0);
            chk($sformatf("%s_in_valid[%0d]", tag, g), in_valid[g], 1'b0);
            chk($sformatf("%s_in_data[%0d]", tag, g), in_data[g], 8'h00);
            chk($sformatf("%s_busy[%0d]", tag, g), busy[g], 1'b0);
            chk($sformatf("%s_pkts[%0d]", tag, g), pkts[g], 16'h0);
        end
    endtask

    // in_ready driver: random, always-on, or a directed 5-cycle stall.
    always begin
        @(posedge clk); #1;
        if (stall_cnt > 0) begin
            stall_cnt--;
            in_ready = 1'b0;
        end else if (stall_arm && bytes_seen[0] == stall_at) begin
            stall_arm = 1'b0;
            stall_cnt = 4;
            in_ready  = 1'b0;
        end else if (rdy_rand) begin
            in_ready = ($urandom_range(0, 9) < 7);
        end else begin
            in_ready = 1'b1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_mon
        bit         prev_v = 1'b0, prev_hs = 1'b0, prev_last = 1'b0;
        logic [7:0] prev_d = 8'h00;
        always @(negedge clk) begin
            logic [8:0] e;
            bit         last_now;
            last_now = 1'b0;
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (prev_v) begin
                    if (prev_hs && prev_last) begin
                        chk($sformatf("valid_after_csum[%0d]", g), in_valid[g], 1'b0);
                        chk($sformatf("packets_sent[%0d]", g), pkts[g], 16'(model_pkts[g]));
                        chk($sformatf("ready_after_pkt[%0d]", g), word_ready[g], 1'b1);
                    end else if (prev_hs) begin
                        chk($sformatf("no_bubble[%0d]", g), in_valid[g], 1'b1);
                    end else begin
                        chk($sformatf("stall_valid[%0d]", g), in_valid[g], 1'b1);
                        chk($sformatf("stall_data[%0d]", g), in_data[g], prev_d);
                    end
                end
                if (in_valid[g]) begin
                    chk($sformatf("busy_ready[%0d]", g), {busy[g], word_ready[g]}, 2'b10);
                    if (in_ready) begin
                        bytes_seen[g]++;
                        if (exp_q[g].size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL unexpected_byte[%0d]: got %02h, none expected", g, in_data[g]);
                        end else begin
                            e = exp_q[g].pop_front();
                            chk($sformatf("byte[%0d]", g), in_data[g], e[7:0]);
                            last_now = e[8];
                            if (last_now) model_pkts[g]++;
                        end
                    end
                end
                prev_v    = in_valid[g];
                prev_d    = in_data[g];
                prev_hs   = in_valid[g] && in_ready;
                prev_last = last_now;
            end
        end
    end

    initial begin
        int base, t;
        model_pkts[0] = 0; model_pkts[1] = 0;
        bytes_seen[0] = 0; bytes_seen[1] = 0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        send_word(32'h12345678, 1'b1, 1'b0);
        wait_idle();
        send_word(32'hDEADBEEF, 1'b0, 1'b0);
        send_word(32'h00000001, 1'b1, 1'b0);
        wait_idle();

        // Auto-close on full; the fifth word stalls until FILL.
        for (int i = 0; i < 4; i++) send_word(32'(i), 1'b0, 1'b0);
        send_word(32'h00000005, 1'b1, 1'b0);
        wait_idle();

        // Last on the word that fills the buffer: one packet only.
        for (int i = 0; i < 3; i++) send_word(32'h1000 + 32'(i), 1'b0, 1'b0);
        send_word(32'h2000, 1'b1, 1'b0);
        wait_idle();

        stall_at  = bytes_seen[0] + 4;
        stall_arm = 1'b1;
        send_word(32'hA1B2C3D4, 1'b0, 1'b0);
        send_word(32'h55667788, 1'b1, 1'b0);
        wait_idle();

        do_flush();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("flush_empty_idle", {in_valid[0], in_valid[1]}, 2'b00);
        end
        @(posedge clk); #1;
        send_word(32'h0BADF00D, 1'b0, 1'b0);
        do_flush();
        wait_idle();
        send_word(32'h11223344, 1'b0, 1'b0);
        send_word(32'h99AABBCC, 1'b0, 1'b1);
        wait_idle();

        // Reset in the middle of a payload.
        send_word(32'hCAFE0001, 1'b0, 1'b0);
        send_word(32'hCAFE0002, 1'b0, 1'b0);
        send_word(32'hCAFE0003, 1'b1, 1'b0);
        base = bytes_seen[0];
        t = 0;
        while (bytes_seen[0] < base + 4 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("reach_payload", 32'(t < 200), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        exp_q[0].delete(); exp_q[1].delete(); model_buf.delete();
        model_pkts[0] = 0; model_pkts[1] = 0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_word(32'h000000FF, 1'b1, 1'b0);
        wait_idle();
        chk("pkts_after_reset", pkts[0], 16'd1);

        rdy_rand = 1'b1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_flush();
            end else begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                send_word($urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
            end
        end
        if (model_buf.size() > 0) do_flush();
        wait_idle();
        chk("pkts_total_be", pkts[0], 16'(model_pkts[0]));
        chk("pkts_total_le", pkts[1], 16'(model_pkts[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
